inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, SHALL set the width of every PC/address port.
REQ-002 Parameter RESET_PC, default 32'h1c000000, SHALL be the first fetch address after reset.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 flush  input  1  SHALL be the IF-stage redirect strobe (bit 4 of the pipeline flush vector).
REQ-006 flush_pc  input  ADDR_WIDTH  SHALL be the redirect target, valid while flush=1.
REQ-007 inst_req  output  1  SHALL be the instruction-bus request valid.
REQ-008 inst_addr  output  ADDR_WIDTH  SHALL be the request address.
REQ-009 inst_addr_ok  input  1  SHALL signal address accepted; handshake completes when inst_req and inst_addr_ok are both 1.
REQ-010 inst_data_ok  input  1  SHALL signal read data valid for the oldest accepted request.
REQ-011 inst_rdata  input  32  SHALL be the instruction word, valid with inst_data_ok.
REQ-012 id_valid  output  1  SHALL mark id_pc/id_inst valid toward decode.
REQ-013 id_ready  input  1  SHALL be the decode accept; transfer occurs when id_valid and id_ready are both 1.
REQ-014 id_pc  output  ADDR_WIDTH  SHALL be the PC of the delivered instruction.
REQ-015 id_inst  output  32  SHALL be the delivered instruction word.

Function
REQ-016 FSM states SHALL be IDLE, REQ, WAIT and DISCARD.
REQ-017 At most one bus request SHALL be outstanding at any time.
REQ-018 IDLE SHALL go to REQ unconditionally on the next cycle.
REQ-019 In REQ, inst_req SHALL be 1 only when the output buffer is empty or is being drained that cycle.
REQ-020 On an address handshake, the FSM SHALL go to WAIT and latch req_pc=pc.
REQ-021 Once asserted, inst_req and inst_addr SHALL hold stable until inst_addr_ok; flush is the only exception, and it may retract the request.
REQ-022 In WAIT, on inst_data_ok the block SHALL write {req_pc, inst_rdata} into the one-entry output buffer, set pc=req_pc+4 (wrapping modulo 2^ADDR_WIDTH), and go to REQ.
REQ-023 id_valid SHALL rise the cycle after inst_data_ok, giving 1-cycle data-to-decode latency.
REQ-024 The buffer SHALL hold id_pc/id_inst stable while id_valid=1 and id_ready=0.
REQ-025 Flush SHALL take priority over all other events: set pc=flush_pc and clear the buffer (id_valid=0 on the next cycle).
REQ-026 Flush target state: in WAIT, or in REQ with an address handshake that same cycle, the FSM SHALL go to DISCARD; otherwise it SHALL go to REQ.
REQ-027 If flush and inst_data_ok coincide in WAIT, the returned data SHALL be dropped and the FSM SHALL go to REQ.
REQ-028 DISCARD SHALL assert no inst_req, SHALL drop data on inst_data_ok, and SHALL then go to REQ.
REQ-029 A flush received in DISCARD SHALL update pc only; the FSM SHALL remain in DISCARD.
REQ-030 A flush coinciding with an id transfer SHALL still clear the buffer.
REQ-031 Data from any request issued before a flush SHALL never reach id_valid.

Reset
REQ-032 Asserting rst_n=0 SHALL immediately set: state=IDLE, pc=RESET_PC, inst_req=0, id_valid=0, id_pc=0, id_inst=0.
REQ-033 Reset asserted while a request is outstanding SHALL abandon that request; the bus side is reset together with this block.

Structure
REQ-034 A shared package SHALL hold ADDR_WIDTH, RESET_PC and the fetch-state enum.
REQ-035 The output buffer SHALL be a sub-module, fetch_out_buf: one entry, valid/ready, with a synchronous clear input.

Verification
REQ-036 Reset release, addr_ok=1 every cycle, data_ok 1 cycle after each accept, id_ready=1 -> inst_addr sequence 1c000000, 1c000004, 1c000008; id_pc matches, one cycle after each data_ok.
REQ-037 id_ready=0 for 5 cycles with the buffer full -> inst_req=0 and id_pc/id_inst held; first request issued in the cycle id_ready returns to 1.
REQ-038 Flush (flush_pc=1c000100) in WAIT, then data_ok 3 cycles later -> data dropped; next inst_addr=1c000100; id_pc never shows the stale PC.
REQ-039 Flush in the same cycle as data_ok -> no id_valid for that data; next request at flush_pc.
REQ-040 Two flushes in DISCARD (1c000200, then 1c000300) -> next request at 1c000300 after data_ok.
REQ-041 rst_n pulsed low while in WAIT -> outputs reach reset values asynchronously; first request after release at 1c000000.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared constants and the fetch FSM state type for the instruction-fetch stage.
package inst_fetch_pkg;

    localparam int          ADDR_WIDTH = 32;
    localparam int          INST_WIDTH = 32;
    localparam logic [31:0] RESET_PC   = 32'h1c00_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction-bus and decode-side signals of the fetch stage, bundled with master/slave views.
interface inst_fetch_if #(
    parameter int ADDR_WIDTH = 32
);
    // Bus: a request is accepted when inst_req && inst_addr_ok; once raised, inst_req/inst_addr
    // stay stable until accepted (a flush may retract them). inst_data_ok returns the oldest
    // accepted request. Decode: a word moves when id_valid && id_ready; id_pc/id_inst are held
    // while id_valid is high and id_ready is low.
    logic                  inst_req;
    logic [ADDR_WIDTH-1:0] inst_addr;
    logic                  inst_addr_ok;
    logic                  inst_data_ok;
    logic [31:0]           inst_rdata;
    logic                  id_valid;
    logic                  id_ready;
    logic [ADDR_WIDTH-1:0] id_pc;
    logic [31:0]           id_inst;

    modport master (
        output inst_req, inst_addr, id_valid, id_pc, id_inst,
        input  inst_addr_ok, inst_data_ok, inst_rdata, id_ready
    );

    modport slave (
        input  inst_req, inst_addr, id_valid, id_pc, id_inst,
        output inst_addr_ok, inst_data_ok, inst_rdata, id_ready
    );
endinterface

// File: rtl/inst_fetch_out_buf.sv
// One-entry valid/ready buffer between the fetch FSM and decode, with a synchronous clear.
module fetch_out_buf
    import inst_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = inst_fetch_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_pc,
    input  logic [INST_WIDTH-1:0] in_inst,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [INST_WIDTH-1:0] out_inst
);

    logic                  valid;
    logic [ADDR_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] inst;

    // Accepts a new word when empty or when the current one leaves this cycle.
    assign in_ready  = !valid || out_ready;
    assign out_valid = valid;
    assign out_pc    = pc;
    assign out_inst  = inst;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            pc    <= '0;
            inst  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            valid <= 1'b1;
            pc    <= in_pc;
            inst  <= in_inst;
        end else if (out_ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: one outstanding bus request, flush redirect with stale-data discard.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = inst_fetch_pkg::ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(inst_fetch_pkg::RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] flush_pc,
    inst_fetch_if.master          bus,
    output fetch_state_e          fsm_state
);

    fetch_state_e          state, state_next;
    logic [ADDR_WIDTH-1:0] pc, pc_next;
    logic [ADDR_WIDTH-1:0] req_pc, req_pc_next;
    logic                  req;
    logic                  addr_hs;
    logic                  buf_wr;
    logic                  buf_in_ready;
    logic                  buf_out_valid;
    logic [ADDR_WIDTH-1:0] buf_out_pc;
    logic [INST_WIDTH-1:0] buf_out_inst;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
        end else begin
            state  <= state_next;
            pc     <= pc_next;
            req_pc <= req_pc_next;
        end
    end

    always_comb begin
        state_next  = state;
        pc_next     = pc;
        req_pc_next = req_pc;
        req         = 1'b0;
        addr_hs     = 1'b0;
        buf_wr      = 1'b0;
        case (state)
            IDLE: state_next = REQ;
            REQ: begin
                // Only ask for a word when there is guaranteed room for its data.
                req     = buf_in_ready;
                addr_hs = req && bus.inst_addr_ok;
                if (addr_hs) begin
                    state_next  = WAIT;
                    req_pc_next = pc;
                end
            end
            WAIT: begin
                if (bus.inst_data_ok) begin
                    buf_wr     = 1'b1;
                    pc_next    = req_pc + ADDR_WIDTH'(4);
                    state_next = REQ;
                end
            end
            DISCARD: begin
                if (bus.inst_data_ok) state_next = REQ;
            end
            default: state_next = IDLE;
        endcase

        // A redirect overrides everything; an in-flight request must be drained and dropped.
        if (flush) begin
            pc_next = flush_pc;
            buf_wr  = 1'b0;
            case (state)
                REQ:     state_next = addr_hs ? DISCARD : REQ;
                WAIT:    state_next = bus.inst_data_ok ? REQ : DISCARD;
                DISCARD: state_next = bus.inst_data_ok ? REQ : DISCARD;
                default: state_next = REQ;
            endcase
        end
    end

    fetch_out_buf #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_out_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (flush),
        .in_valid (buf_wr),
        .in_ready (buf_in_ready),
        .in_pc    (req_pc),
        .in_inst  (bus.inst_rdata),
        .out_valid(buf_out_valid),
        .out_ready(bus.id_ready),
        .out_pc   (buf_out_pc),
        .out_inst (buf_out_inst)
    );

    assign bus.inst_req  = req;
    assign bus.inst_addr = pc;
    assign bus.id_valid  = buf_out_valid;
    assign bus.id_pc     = buf_out_pc;
    assign bus.id_inst   = buf_out_inst;
    assign fsm_state     = state;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed scoreboard bench for inst_fetch: bus responder, request/delivery monitors, scenarios.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    localparam int AW = 32;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic [AW-1:0] flush_pc;
    fetch_state_e  fsm_state;

    inst_fetch_if #(.ADDR_WIDTH(AW)) bus ();

    inst_fetch #(
        .ADDR_WIDTH(AW),
        .RESET_PC  (32'h1c00_0000)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .flush_pc (flush_pc),
        .bus      (bus),
        .fsm_state(fsm_state)
    );

    int            n_checks;
    int            n_fail;
    logic [AW-1:0] addr_q[$];
    logic [AW-1:0] exp_q[$];

    bit            pend;
    int            cnt;
    logic [AW-1:0] paddr;
    int            data_delay;
    int            n_accepts;
    int            cyc;
    int            last_dok;

    bit            prev_req, prev_aok, prev_flush, prev_valid, prev_ready;
    logic [AW-1:0] prev_addr, prev_pc;
    logic [31:0]   prev_inst;

    function automatic logic [31:0] inst_of(input logic [AW-1:0] a);
        return a ^ 32'h5a5a_0f0f;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // Bus responder and monitors: drive just after the rising edge, sample at the falling edge.
    initial begin
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = '0;
        pend = 1'b0; cnt = 0; paddr = '0; n_accepts = 0; cyc = 0; last_dok = -10;
        prev_req = 0; prev_aok = 0; prev_flush = 0; prev_valid = 0; prev_ready = 0;
        prev_addr = '0; prev_pc = '0; prev_inst = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.inst_data_ok = 1'b0;
            if (pend && rst_n) begin
                if (cnt <= 1) begin
                    bus.inst_data_ok = 1'b1;
                    bus.inst_rdata   = inst_of(paddr);
                    pend = 1'b0;
                end else begin
                    cnt--;
                end
            end
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                pend = 1'b0;
                prev_req = 0; prev_aok = 0; prev_flush = 0; prev_valid = 0; prev_ready = 0;
            end else begin
                if (bus.inst_req && bus.inst_addr_ok) begin
                    check("one_outstanding", 64'(pend), 64'(0));
                    if (addr_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL inst_addr: got unexpected request %h expected none", bus.inst_addr);
                    end else begin
                        check("inst_addr", 64'(bus.inst_addr), 64'(addr_q.pop_front()));
                    end
                    pend = 1'b1;
                    cnt = data_delay;
                    paddr = bus.inst_addr;
                    n_accepts++;
                end
                if (prev_req && !prev_aok && !prev_flush) begin
                    check("req_hold", 64'(bus.inst_req), 64'(1));
                    check("addr_hold", 64'(bus.inst_addr), 64'(prev_addr));
                end
                if (prev_valid && !prev_ready && !prev_flush) begin
                    check("id_hold_valid", 64'(bus.id_valid), 64'(1));
                    check("id_hold_pc", 64'(bus.id_pc), 64'(prev_pc));
                    check("id_hold_inst", 64'(bus.id_inst), 64'(prev_inst));
                end
                if (bus.id_valid && !(prev_valid && !prev_ready))
                    check("id_latency", 64'(cyc), 64'(last_dok + 1));
                if (bus.inst_data_ok && !flush) last_dok = cyc;
                if (bus.id_valid && bus.id_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL id_pc: got unexpected delivery %h expected none", bus.id_pc);
                    end else begin
                        logic [AW-1:0] e;
                        e = exp_q.pop_front();
                        check("id_pc", 64'(bus.id_pc), 64'(e));
                        check("id_inst", 64'(bus.id_inst), 64'(inst_of(e)));
                    end
                end
                prev_req   = bus.inst_req;
                prev_aok   = bus.inst_addr_ok;
                prev_flush = flush;
                prev_valid = bus.id_valid;
                prev_ready = bus.id_ready;
                prev_addr  = bus.inst_addr;
                prev_pc    = bus.id_pc;
                prev_inst  = bus.id_inst;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accepts(input int target);
        for (int i = 0; i < 60 && n_accepts < target; i++) @(posedge clk);
        #1;
        check("accept_timeout", 64'(n_accepts >= target), 64'(1));
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60; i++) begin
            step();
            if (exp_q.size() == 0 && !pend) break;
        end
        check("drain", 64'(exp_q.size() == 0 && !pend), 64'(1));
        check("addr_q_empty", 64'(addr_q.size()), 64'(0));
    endtask

    initial begin
        rst_n = 1'b1;
        flush = 1'b0;
        flush_pc = '0;
        bus.inst_addr_ok = 1'b0;
        bus.id_ready = 1'b1;
        data_delay = 1;
        n_checks = 0;
        n_fail = 0;

        // Reset values, observed before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("rst_state", 64'(fsm_state), 64'(IDLE));
        check("rst_inst_req", 64'(bus.inst_req), 64'(0));
        check("rst_id_valid", 64'(bus.id_valid), 64'(0));
        check("rst_id_pc", 64'(bus.id_pc), 64'(0));
        check("rst_id_inst", 64'(bus.id_inst), 64'(0));
        step();
        step();

        // Streaming fetch from the reset PC.
        rst_n = 1'b1;
        addr_q.push_back(32'h1c00_0000); addr_q.push_back(32'h1c00_0004); addr_q.push_back(32'h1c00_0008);
        exp_q.push_back(32'h1c00_0000);  exp_q.push_back(32'h1c00_0004);  exp_q.push_back(32'h1c00_0008);
        bus.inst_addr_ok = 1'b1;
        wait_accepts(3);
        bus.inst_addr_ok = 1'b0;
        wait_drain();

        // Decode stall with a full buffer: no request, outputs held, request resumes with ready.
        bus.id_ready = 1'b0;
        addr_q.push_back(32'h1c00_000c); addr_q.push_back(32'h1c00_0010);
        exp_q.push_back(32'h1c00_000c);  exp_q.push_back(32'h1c00_0010);
        bus.inst_addr_ok = 1'b1;
        wait_accepts(4);
        step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_inst_req", 64'(bus.inst_req), 64'(0));
            check("stall_id_valid", 64'(bus.id_valid), 64'(1));
            check("stall_id_pc", 64'(bus.id_pc), 64'(32'h1c00_000c));
            check("stall_id_inst", 64'(bus.id_inst), 64'(inst_of(32'h1c00_000c)));
        end
        step();
        bus.id_ready = 1'b1;
        @(negedge clk);
        check("resume_inst_req", 64'(bus.inst_req), 64'(1));
        check("resume_inst_addr", 64'(bus.inst_addr), 64'(32'h1c00_0010));
        wait_accepts(5);
        bus.inst_addr_ok = 1'b0;
        wait_drain();

        // Flush in WAIT, data returns three cycles later and is dropped.
        addr_q.push_back(32'h1c00_0014); addr_q.push_back(32'h1c00_0100);
        exp_q.push_back(32'h1c00_0100);
        data_delay = 4;
        bus.inst_addr_ok = 1'b1;
        wait_accepts(6);
        flush = 1'b1; flush_pc = 32'h1c00_0100; data_delay = 1;
        step();
        flush = 1'b0;
        @(negedge clk);
        check("discard_state", 64'(fsm_state), 64'(DISCARD));
        check("discard_no_req", 64'(bus.inst_req), 64'(0));
        wait_accepts(7);
        bus.inst_addr_ok = 1'b0;
        wait_drain();

        // Flush coinciding with data_ok: data dropped, next request at the target.
        addr_q.push_back(32'h1c00_0104); addr_q.push_back(32'h1c00_0180);
        exp_q.push_back(32'h1c00_0180);
        data_delay = 3;
        bus.inst_addr_ok = 1'b1;
        wait_accepts(8);
        step();
        step();
        flush = 1'b1; flush_pc = 32'h1c00_0180; data_delay = 1;
        step();
        flush = 1'b0;
        @(negedge clk);
        check("coinc_id_valid", 64'(bus.id_valid), 64'(0));
        check("coinc_state", 64'(fsm_state), 64'(REQ));
        check("coinc_inst_req", 64'(bus.inst_req), 64'(1));
        check("coinc_inst_addr", 64'(bus.inst_addr), 64'(32'h1c00_0180));
        wait_accepts(9);
        bus.inst_addr_ok = 1'b0;
        wait_drain();

        // Two further flushes while discarding: the last target wins.
        addr_q.push_back(32'h1c00_0184); addr_q.push_back(32'h1c00_0300);
        exp_q.push_back(32'h1c00_0300);
        data_delay = 5;
        bus.inst_addr_ok = 1'b1;
        wait_accepts(10);
        flush = 1'b1; flush_pc = 32'h1c00_0500; data_delay = 1;
        step();
        flush_pc = 32'h1c00_0200;
        step();
        flush_pc = 32'h1c00_0300;
        step();
        flush = 1'b0;
        @(negedge clk);
        check("dbl_state", 64'(fsm_state), 64'(DISCARD));
        check("dbl_no_req", 64'(bus.inst_req), 64'(0));
        wait_accepts(11);
        bus.inst_addr_ok = 1'b0;
        wait_drain();

        // Reset pulse while waiting for data: asynchronous effect, refetch from the reset PC.
        addr_q.push_back(32'h1c00_0304); addr_q.push_back(32'h1c00_0000);
        exp_q.push_back(32'h1c00_0000);
        data_delay = 4;
        bus.inst_addr_ok = 1'b1;
        wait_accepts(12);
        #2 rst_n = 1'b0;
        #1;
        check("arst_state", 64'(fsm_state), 64'(IDLE));
        check("arst_inst_req", 64'(bus.inst_req), 64'(0));
        check("arst_id_valid", 64'(bus.id_valid), 64'(0));
        check("arst_id_pc", 64'(bus.id_pc), 64'(0));
        check("arst_id_inst", 64'(bus.id_inst), 64'(0));
        step();
        step();
        data_delay = 1;
        rst_n = 1'b1;
        wait_accepts(13);
        bus.inst_addr_ok = 1'b0;
        wait_drain();

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
